// File: rtl/udp_rx_pkg.sv
// Shared definitions for the UDP receive path: FSM encoding, header size
// and the board's default address/port.
package udp_rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DROP = 2'd2
  } rxb_state_t;

  localparam int unsigned UDP_HDR_BYTES      = 8;
  localparam logic [31:0] DEFAULT_BOARD_IP   = 32'hC0A8_0002;
  localparam logic [15:0] DEFAULT_BOARD_PORT = 16'h1F90;

  // A UDP length shorter than the header yields a value with bit 16 set,
  // which any length limit check then rejects.
  function automatic logic [16:0] payload_bytes(input logic [15:0] udp_len);
    return {1'b0, udp_len} - 17'(UDP_HDR_BYTES);
  endfunction

endpackage

// File: rtl/sat_cnt16.sv
// 16-bit event counter that holds at 16'hFFFF instead of wrapping.
module sat_cnt16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [15:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/udp_rx_buf_ctrl.sv
// Ping-pong receive buffer controller: filters UDP frames by IP/port, writes
// accepted payload words into one of two RAM banks and hands them out in order.
module udp_rx_buf_ctrl
  import udp_rx_pkg::*;
#(
  parameter logic [31:0] BOARD_IP   = DEFAULT_BOARD_IP,
  parameter logic [15:0] BOARD_PORT = DEFAULT_BOARD_PORT,
  parameter int unsigned ADDR_W     = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_word_valid,
  input  logic [31:0]       rx_word,
  input  logic              rx_frame_done,
  input  logic              rx_abort,
  input  logic [31:0]       rx_dst_ip,
  input  logic [15:0]       rx_dst_port,
  input  logic [15:0]       rx_udp_len,
  output logic              ram_we,
  output logic [ADDR_W:0]   ram_waddr,
  output logic [31:0]       ram_wdata,
  output logic              buf_valid,
  output logic              buf_bank,
  output logic [ADDR_W:0]   buf_words,
  output logic [15:0]       buf_bytes,
  input  logic              buf_release,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       drop_cnt
);

  localparam logic [ADDR_W:0] DEPTH     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] PTR_ONE   = (ADDR_W+1)'(1);
  localparam logic [16:0]     MAX_BYTES = 17'(4) << ADDR_W;

  rxb_state_t      state, state_nx;
  logic            wr_bank, rd_bank;
  logic [1:0]      full, full_nx;
  logic [ADDR_W:0] wr_ptr, wr_ptr_nx;
  logic [ADDR_W:0] words_q [2];
  logic [15:0]     bytes_q [2];

  logic            hdr_ok, release_ok, commit, drop;
  logic            we_nx;
  logic [ADDR_W:0] waddr_nx;
  logic [16:0]     payload_len;

  always_comb begin
    payload_len = payload_bytes(rx_udp_len);
    hdr_ok      = (rx_dst_ip == BOARD_IP) && (rx_dst_port == BOARD_PORT) &&
                  !full[wr_bank] && (payload_len <= MAX_BYTES);
    release_ok  = buf_release && full[rd_bank];
  end

  // A first word arriving together with done/abort is resolved in the same
  // cycle so that single-word frames never leave the FSM stranded in FILL.
  always_comb begin
    state_nx  = state;
    wr_ptr_nx = wr_ptr;
    we_nx     = 1'b0;
    waddr_nx  = {wr_bank, wr_ptr[ADDR_W-1:0]};
    commit    = 1'b0;
    drop      = 1'b0;
    unique case (state)
      IDLE: begin
        if (rx_word_valid) begin
          if (hdr_ok) begin
            we_nx     = 1'b1;
            waddr_nx  = {wr_bank, {ADDR_W{1'b0}}};
            wr_ptr_nx = PTR_ONE;
            if (rx_abort) begin
              drop      = 1'b1;
              wr_ptr_nx = '0;
            end else if (rx_frame_done) begin
              commit = 1'b1;
            end else begin
              state_nx = FILL;
            end
          end else if (rx_frame_done || rx_abort) begin
            drop = 1'b1;
          end else begin
            state_nx = DROP;
          end
        end
      end
      FILL: begin
        if (rx_abort) begin
          drop      = 1'b1;
          wr_ptr_nx = '0;
          state_nx  = IDLE;
        end else if (rx_word_valid && (wr_ptr == DEPTH)) begin
          wr_ptr_nx = '0;
          if (rx_frame_done) begin
            drop     = 1'b1;
            state_nx = IDLE;
          end else begin
            state_nx = DROP;
          end
        end else begin
          if (rx_word_valid) begin
            we_nx     = 1'b1;
            wr_ptr_nx = wr_ptr + PTR_ONE;
          end
          if (rx_frame_done) begin
            commit   = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      DROP: begin
        if (rx_frame_done || rx_abort) begin
          drop     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Commit and release always address different banks, so both may apply.
  always_comb begin
    full_nx = full;
    if (commit)     full_nx[wr_bank] = 1'b1;
    if (release_ok) full_nx[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      full       <= '0;
      wr_ptr     <= '0;
      words_q[0] <= '0;
      words_q[1] <= '0;
      bytes_q[0] <= '0;
      bytes_q[1] <= '0;
      ram_we     <= 1'b0;
      ram_waddr  <= '0;
      ram_wdata  <= '0;
    end else begin
      state  <= state_nx;
      wr_ptr <= commit ? '0 : wr_ptr_nx;
      full   <= full_nx;
      if (commit) begin
        words_q[wr_bank] <= wr_ptr_nx;
        bytes_q[wr_bank] <= payload_len[15:0];
        wr_bank          <= ~wr_bank;
      end
      if (release_ok) rd_bank <= ~rd_bank;
      ram_we <= we_nx;
      if (we_nx) begin
        ram_waddr <= waddr_nx;
        ram_wdata <= rx_word;
      end
    end
  end

  always_comb begin
    buf_valid = full[rd_bank];
    buf_bank  = rd_bank;
    buf_words = words_q[rd_bank];
    buf_bytes = bytes_q[rd_bank];
  end

  sat_cnt16 u_frame_cnt (
    .clk (clk),
    .rst (rst),
    .inc (commit),
    .cnt (frame_cnt)
  );

  sat_cnt16 u_drop_cnt (
    .clk (clk),
    .rst (rst),
    .inc (drop),
    .cnt (drop_cnt)
  );

endmodule

// File: tb/tb_udp_rx_buf_ctrl.sv
// Scoreboard bench for udp_rx_buf_ctrl with a 4-word bank (ADDR_W=2).
module tb_udp_rx_buf_ctrl;

  localparam int unsigned AW   = 2;
  localparam logic [31:0] IP   = 32'hC0A8_0002;
  localparam logic [15:0] PORT = 16'h1F90;
  localparam logic [31:0] STEP = 32'h1111_1111;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_word_valid = 1'b0;
  logic [31:0]   rx_word = '0;
  logic          rx_frame_done = 1'b0;
  logic          rx_abort = 1'b0;
  logic [31:0]   rx_dst_ip = '0;
  logic [15:0]   rx_dst_port = '0;
  logic [15:0]   rx_udp_len = '0;
  logic          ram_we;
  logic [AW:0]   ram_waddr;
  logic [31:0]   ram_wdata;
  logic          buf_valid;
  logic          buf_bank;
  logic [AW:0]   buf_words;
  logic [15:0]   buf_bytes;
  logic          buf_release = 1'b0;
  logic [15:0]   frame_cnt;
  logic [15:0]   drop_cnt;

  typedef struct { logic [AW:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic bank; logic [AW:0] words; logic [15:0] bytes; } bd_t;

  wr_t wq[$];
  bd_t bq[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  logic prev_v = 1'b0;
  logic prev_b = 1'b0;

  udp_rx_buf_ctrl #(.BOARD_IP(IP), .BOARD_PORT(PORT), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .rx_word_valid(rx_word_valid), .rx_word(rx_word),
    .rx_frame_done(rx_frame_done), .rx_abort(rx_abort),
    .rx_dst_ip(rx_dst_ip), .rx_dst_port(rx_dst_port), .rx_udp_len(rx_udp_len),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .buf_valid(buf_valid), .buf_bank(buf_bank), .buf_words(buf_words),
    .buf_bytes(buf_bytes), .buf_release(buf_release),
    .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops an expected entry for every RAM write and for every new
  // buffer presentation (valid rising, or bank changing while valid).
  always @(negedge clk) begin
    if (rst) begin
      prev_v <= 1'b0;
      prev_b <= 1'b0;
    end else begin
      if (ram_we) begin
        if (wq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL ram_write_unexpected: got addr 0x%0h data 0x%0h, expected no write",
                   ram_waddr, ram_wdata);
        end else begin
          wr_t e;
          e = wq.pop_front();
          check("ram_waddr", 64'(ram_waddr), 64'(e.addr));
          check("ram_wdata", 64'(ram_wdata), 64'(e.data));
        end
      end
      if (buf_valid && !(prev_v && (prev_b == buf_bank))) begin
        if (bq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL buf_unexpected: got bank %0d words %0d bytes %0d, expected none",
                   buf_bank, buf_words, buf_bytes);
        end else begin
          bd_t b;
          b = bq.pop_front();
          check("buf_bank",  64'(buf_bank),  64'(b.bank));
          check("buf_words", 64'(buf_words), 64'(b.words));
          check("buf_bytes", 64'(buf_bytes), 64'(b.bytes));
        end
      end
      prev_v <= buf_valid;
      prev_b <= buf_bank;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic exp_writes(input logic bank, input int n, input logic [31:0] seed);
    for (int i = 0; i < n; i++) begin
      wq.push_back('{addr: {bank, AW'(i)}, data: seed + 32'(i) * STEP});
    end
  endtask

  task automatic exp_buf(input logic bank, input logic [AW:0] words, input logic [15:0] bytes);
    bq.push_back('{bank: bank, words: words, bytes: bytes});
  endtask

  task automatic send_frame(input logic [15:0] port, input logic [15:0] len, input int n,
                            input logic [31:0] seed, input bit abort, input bit rel);
    rx_dst_ip   = IP;
    rx_dst_port = port;
    rx_udp_len  = len;
    for (int i = 0; i < n; i++) begin
      rx_word_valid = 1'b1;
      rx_word       = seed + 32'(i) * STEP;
      tick();
    end
    rx_word_valid = 1'b0;
    if (abort) rx_abort = 1'b1;
    else       rx_frame_done = 1'b1;
    buf_release = rel;
    tick();
    rx_abort      = 1'b0;
    rx_frame_done = 1'b0;
    buf_release   = 1'b0;
  endtask

  task automatic release_buf();
    buf_release = 1'b1;
    tick();
    buf_release = 1'b0;
  endtask

  task automatic drain(input string name);
    tick();
    tick();
    check({name, "_wq_empty"}, 64'(wq.size()), 64'd0);
    check({name, "_bq_empty"}, 64'(bq.size()), 64'd0);
  endtask

  initial begin
    do_reset();
    check("rst_ram_we",    64'(ram_we),    64'd0);
    check("rst_ram_waddr", 64'(ram_waddr), 64'd0);
    check("rst_ram_wdata", 64'(ram_wdata), 64'd0);
    check("rst_buf_valid", 64'(buf_valid), 64'd0);
    check("rst_buf_bank",  64'(buf_bank),  64'd0);
    check("rst_buf_words", 64'(buf_words), 64'd0);
    check("rst_buf_bytes", 64'(buf_bytes), 64'd0);
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("rst_drop_cnt",  64'(drop_cnt),  64'd0);

    // Matching 4-word frame, then an empty-payload done that must be ignored.
    exp_writes(1'b0, 4, 32'h1111_1111);
    exp_buf(1'b0, 3'd4, 16'd16);
    send_frame(PORT, 16'd24, 4, 32'h1111_1111, 1'b0, 1'b0);
    tick();
    check("t1_frame_cnt", 64'(frame_cnt), 64'd1);
    check("t1_drop_cnt",  64'(drop_cnt),  64'd0);
    check("t1_buf_valid", 64'(buf_valid), 64'd1);
    rx_frame_done = 1'b1;
    tick();
    rx_frame_done = 1'b0;
    tick();
    check("t1_empty_frame_cnt", 64'(frame_cnt), 64'd1);
    check("t1_empty_drop_cnt",  64'(drop_cnt),  64'd0);
    drain("t1");

    // Wrong port.
    do_reset();
    send_frame(16'h1F91, 16'd16, 2, 32'h0A0A_0000, 1'b0, 1'b0);
    tick();
    check("t2_drop_cnt",  64'(drop_cnt),  64'd1);
    check("t2_frame_cnt", 64'(frame_cnt), 64'd0);
    check("t2_buf_valid", 64'(buf_valid), 64'd0);
    drain("t2");

    // Both banks full: third frame dropped, fourth accepted after a release.
    do_reset();
    exp_writes(1'b0, 3, 32'h0100_0000);
    exp_buf(1'b0, 3'd3, 16'd12);
    send_frame(PORT, 16'd20, 3, 32'h0100_0000, 1'b0, 1'b0);
    exp_writes(1'b1, 2, 32'h0200_0000);
    exp_buf(1'b1, 3'd2, 16'd8);
    send_frame(PORT, 16'd16, 2, 32'h0200_0000, 1'b0, 1'b0);
    send_frame(PORT, 16'd12, 1, 32'h0300_0000, 1'b0, 1'b0);
    tick();
    check("t3_frame_cnt", 64'(frame_cnt), 64'd2);
    check("t3_drop_cnt",  64'(drop_cnt),  64'd1);
    check("t3_bank_pre",  64'(buf_bank),  64'd0);
    release_buf();
    tick();
    check("t3_bank_post", 64'(buf_bank),  64'd1);
    exp_writes(1'b0, 4, 32'h0400_0000);
    exp_buf(1'b0, 3'd4, 16'd16);
    send_frame(PORT, 16'd24, 4, 32'h0400_0000, 1'b0, 1'b0);
    tick();
    check("t3_frame_cnt4", 64'(frame_cnt), 64'd3);
    release_buf();
    tick();
    release_buf();
    tick();
    check("t3_valid_end", 64'(buf_valid), 64'd0);
    drain("t3");

    // Data overflow: length passes, 5th word overflows the 4-word bank.
    do_reset();
    exp_writes(1'b0, 4, 32'h0500_0000);
    send_frame(PORT, 16'd24, 5, 32'h0500_0000, 1'b0, 1'b0);
    tick();
    check("t4_drop_cnt",  64'(drop_cnt),  64'd1);
    check("t4_frame_cnt", 64'(frame_cnt), 64'd0);
    check("t4_buf_valid", 64'(buf_valid), 64'd0);
    exp_writes(1'b0, 1, 32'h0600_0000);
    exp_buf(1'b0, 3'd1, 16'd4);
    send_frame(PORT, 16'd12, 1, 32'h0600_0000, 1'b0, 1'b0);
    tick();
    check("t4_frame_cnt2", 64'(frame_cnt), 64'd1);
    drain("t4");

    // Abort after two words, next frame restarts at {0,0}.
    do_reset();
    exp_writes(1'b0, 2, 32'h0700_0000);
    send_frame(PORT, 16'd24, 2, 32'h0700_0000, 1'b1, 1'b0);
    tick();
    check("t5_drop_cnt",  64'(drop_cnt),  64'd1);
    check("t5_buf_valid", 64'(buf_valid), 64'd0);
    exp_writes(1'b0, 3, 32'h0800_0000);
    exp_buf(1'b0, 3'd3, 16'd12);
    send_frame(PORT, 16'd20, 3, 32'h0800_0000, 1'b0, 1'b0);
    tick();
    check("t5_frame_cnt", 64'(frame_cnt), 64'd1);
    drain("t5");

    // Commit to bank 1 in the same cycle as release of bank 0.
    do_reset();
    exp_writes(1'b0, 2, 32'h0900_0000);
    exp_buf(1'b0, 3'd2, 16'd8);
    send_frame(PORT, 16'd16, 2, 32'h0900_0000, 1'b0, 1'b0);
    exp_writes(1'b1, 3, 32'h0A00_0000);
    exp_buf(1'b1, 3'd3, 16'd12);
    send_frame(PORT, 16'd20, 3, 32'h0A00_0000, 1'b0, 1'b1);
    tick();
    check("t6_buf_valid", 64'(buf_valid), 64'd1);
    check("t6_buf_bank",  64'(buf_bank),  64'd1);
    check("t6_buf_words", 64'(buf_words), 64'd3);
    check("t6_frame_cnt", 64'(frame_cnt), 64'd2);
    release_buf();
    tick();
    check("t6_valid_end", 64'(buf_valid), 64'd0);
    drain("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/udp_rx_buf_ctrl.md
# udp_rx_buf_ctrl

Ping-pong receive-buffer controller placed between the 100M MII UDP receiver and the frame consumer (command decoder / DMA). Accepts the receiver's 32-bit word stream, filters frames by destination IP and UDP port, and writes accepted frames into one of two RAM banks. Completed banks are handed to the consumer with a valid/release handshake, in arrival order. Overflowing, aborted, mismatched and no-free-bank frames are dropped and counted.

## Interface
- `BOARD_IP`, 32'hC0A8_0002, destination IP accepted
- `BOARD_PORT`, 16'h1F90, destination UDP port accepted
- `ADDR_W`, 9, word-address width of one bank (bank depth = 2^ADDR_W words)

- `clk`  in  1  receive clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `rx_word_valid`  in  1  one-cycle strobe; `rx_word` holds a payload word (big-endian, zero-padded tail)
- `rx_word`  in  32  payload word
- `rx_frame_done`  in  1  one-cycle strobe, frame completed by receiver
- `rx_abort`  in  1  one-cycle strobe, receiver dropped rxdv mid-frame
- `rx_dst_ip`  in  32  header destination IP, stable from first `rx_word_valid` to frame end
- `rx_dst_port`  in  16  header destination port, same stability
- `rx_udp_len`  in  16  UDP length field (header + payload bytes), same stability
- `ram_we`  out  1  bank RAM write enable
- `ram_waddr`  out  ADDR_W+1  {bank, word address}
- `ram_wdata`  out  32  write data
- `buf_valid`  out  1  a committed bank is available to the consumer
- `buf_bank`  out  1  bank holding the oldest committed frame
- `buf_words`  out  ADDR_W+1  words in that bank (1..2^ADDR_W)
- `buf_bytes`  out  16  payload bytes (`rx_udp_len` − 8)
- `buf_release`  in  1  consumer done with `buf_bank`; ignored when `buf_valid`=0
- `frame_cnt`  out  16  committed frames, saturating
- `drop_cnt`  out  16  dropped frames, saturating

## Operation
- State machine: IDLE, FILL, DROP. Registers: `wr_bank`, `rd_bank`, `full[1:0]`, `wr_ptr` (ADDR_W+1 bits), per-bank `words[b]`, `bytes[b]`.
- IDLE, `rx_word_valid`: accept when `rx_dst_ip`==BOARD_IP, `rx_dst_port`==BOARD_PORT, `full[wr_bank]`==0 and `rx_udp_len`−8 ≤ 4·2^ADDR_W. Accept → write the word at {wr_bank,0}, `wr_ptr`←1, go to FILL. Otherwise → DROP, no write.
- IDLE, `rx_frame_done`/`rx_abort` with no word received (empty payload): ignored, no counter change.
- FILL, `rx_word_valid`: when `wr_ptr` < 2^ADDR_W, write at {wr_bank, wr_ptr[ADDR_W-1:0]} and increment. When `wr_ptr` == 2^ADDR_W (overflow), go to DROP; the bank stays free.
- FILL, `rx_frame_done`: commit. `full[wr_bank]`←1, `words[wr_bank]`←`wr_ptr` (including a word strobed in the same cycle), `bytes[wr_bank]`←`rx_udp_len`−8, toggle `wr_bank`, `frame_cnt`++, go to IDLE.
- FILL, `rx_abort`: discard, `drop_cnt`++, go to IDLE. `wr_bank` is not toggled.
- DROP: ignore words. On `rx_frame_done` or `rx_abort`, `drop_cnt`++ and go to IDLE.
- Consumer side: `buf_valid`=`full[rd_bank]`, `buf_bank`=`rd_bank`, `buf_words`/`buf_bytes` = metadata of `rd_bank`. A honored `buf_release` clears `full[rd_bank]` and toggles `rd_bank`.
- Commit and release in the same cycle apply independently. They never target the same bank, because commit requires that bank to be free.
- Counters saturate at 16'hFFFF.

## Timing
- Reset: state=IDLE, `wr_bank`=`rd_bank`=0, `full`=0, `wr_ptr`=0; all outputs 0 (`ram_we`, `ram_waddr`, `ram_wdata`, `buf_*`, counters).
- Reset mid-frame: the frame is lost and not counted. Subsequent words are ignored until the next frame's first `rx_word_valid` in IDLE.
- `ram_we`/`ram_waddr`/`ram_wdata` are registered: 1 cycle after `rx_word_valid`.
- `buf_valid` rises 1 cycle after the commit cycle. It falls, or moves to the other bank, 1 cycle after a honored `buf_release`.
- Both banks full: the next frame goes to DROP at its first word. It is not back-pressured.
- Throughput: a new frame may start the cycle after commit.

## Structure
- Shared package `udp_rx_pkg`:
  - state enum `rxb_state_t` {IDLE, FILL, DROP}
  - `UDP_HDR_BYTES`=8
  - default BOARD_IP/BOARD_PORT constants (also used by the TX path)
- One sub-module, `sat_cnt16`: 16-bit saturating counter with synchronous reset and increment enable, instantiated twice.
- RAM is external; this block only drives the write port.

## Test plan
- Matching frame, `rx_udp_len`=24 (4 words 0x11111111..0x44444444), done → RAM bank 0 addr 0..3 written; `buf_valid`=1, `buf_bank`=0, `buf_words`=4, `buf_bytes`=16, `frame_cnt`=1.
- Wrong port 0x1F91 → no `ram_we`, `drop_cnt`=1, `buf_valid` stays 0.
- Three matching frames without release → banks 0 and 1 committed, third dropped (`drop_cnt`=1). Release → `buf_bank`=1; a fourth frame is then accepted into bank 0.
- ADDR_W=2, frame of 5 words with `rx_udp_len`=24 (length passes, data overflows) → 4 writes, then DROP; bank 0 stays free, `drop_cnt`=1.
- `rx_abort` after 2 words → `drop_cnt`=1; next frame is written from {0,0}, and its `buf_words` is correct.
- Commit to bank 1 in the same cycle as release of bank 0 → `full`=2'b10, `rd_bank`=1, `buf_valid` stays 1 with bank-1 metadata.
